dw_reg_array: RTL and testbench

- Pixel register array directly downstream of the input-buffer interface controller.
- Holds the NREG-lane vertical pixel window feeding the depthwise PE (dwpe).
- Executes the 2-bit reg_array_cmd stream: load from buffer, horizontal shift, or reuse rows from per-lane reuse FIFOs.
- Keeps input-buffer re-reads to only the STRIDE new rows per normal transfer.

---
 rtl/dw_reg_array_if.sv | 42 ++++
 rtl/dw_reg_array.sv | 157 +++++++++++++++
 tb/tb_dw_reg_array.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dw_reg_array_if.sv
// ---------------------------------------------------------------------------
// dw_reg_array_if
// Command/data bundle between the input-buffer controller (master) and the
// pixel register array (slave).
//   arr_en        : command qualifier; reg_array_cmd ignored when low
//   reg_array_cmd : 00 LOAD, 01 SHIFT, 10 REUSE, 11 HOLD
//   fifo_read     : pop enable that turns REUSE into an update
//   flush         : block end; clears window and reuse FIFOs
//   buf_data      : buffer pixels, lane i at [i*DW +: DW]
//   win_data      : current NREG-lane window towards the depthwise PE
//   win_vld       : one-cycle pulse after each window update
//   fifo_empty    : OR of all reuse FIFO empty flags
//   fifo_full     : OR of all reuse FIFO full flags
//   err_ovf       : sticky push-while-full
//   err_udf       : sticky pop-while-empty
// ---------------------------------------------------------------------------
interface dw_reg_array_if #(
    parameter int DW   = 8,
    parameter int NREG = 3
) ();
    logic                arr_en;
    logic [1:0]          reg_array_cmd;
    logic                fifo_read;
    logic                flush;
    logic [NREG*DW-1:0]  buf_data;
    logic [NREG*DW-1:0]  win_data;
    logic                win_vld;
    logic                fifo_empty;
    logic                fifo_full;
    logic                err_ovf;
    logic                err_udf;

    modport master (
        output arr_en, reg_array_cmd, fifo_read, flush, buf_data,
        input  win_data, win_vld, fifo_empty, fifo_full, err_ovf, err_udf
    );

    modport slave (
        input  arr_en, reg_array_cmd, fifo_read, flush, buf_data,
        output win_data, win_vld, fifo_empty, fifo_full, err_ovf, err_udf
    );
endinterface

// File: rtl/dw_reg_array.sv
// ---------------------------------------------------------------------------
// dw_reg_array
// Pixel register array feeding the depthwise PE. Holds an NREG-lane vertical
// window and executes the LOAD / SHIFT / REUSE / HOLD command stream. Lanes
// STRIDE..NREG-1 own a reuse FIFO that captures every value they load, so a
// REUSE can refill the lower lanes without re-reading the input buffer.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous, active-low reset
//   bus   : dw_reg_array_if.slave (command, buffer data, window, status)
//
// Optional feature:
//   DW_REG_ARRAY_ERR_EN : when defined, err_ovf / err_udf are sticky error
//                         flags; otherwise they are tied to 0 and the
//                         detection logic is absent.
// ---------------------------------------------------------------------------
module dw_reg_array #(
    parameter int DW     = 8,
    parameter int NREG   = 3,
    parameter int STRIDE = 1,
    parameter int FDEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dw_reg_array_if.slave  bus
);
    localparam int AW = $clog2(FDEPTH);

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_SHIFT = 2'b01;
    localparam logic [1:0] CMD_REUSE = 2'b10;

    logic [NREG-1:0][DW-1:0] lane_p0;
    logic [NREG-1:0][DW-1:0] next_p0;
    logic                    vld_p0;
    logic                    upd;
    logic                    reuse;
    logic [DW-1:0]           head [NREG];
    logic [NREG-1:0]         empty_f;
    logic [NREG-1:0]         full_f;
`ifdef DW_REG_ARRAY_ERR_EN
    logic [NREG-1:0]         ovf_ev;
    logic [NREG-1:0]         udf_ev;
`endif

    // Command decode; flush overrides any command.
    always_comb begin
        upd   = 1'b0;
        reuse = 1'b0;
        if (bus.arr_en && !bus.flush) begin
            case (bus.reg_array_cmd)
                CMD_LOAD, CMD_SHIFT: upd = 1'b1;
                CMD_REUSE: begin
                    upd   = bus.fifo_read;
                    reuse = bus.fifo_read;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_lane
        // Lower lanes take the head of the FIFO STRIDE lanes above on REUSE;
        // an empty FIFO yields 0.
        if (i < NREG - STRIDE) begin : g_reuse_src
            assign next_p0[i] = reuse ? (empty_f[i+STRIDE] ? '0 : head[i+STRIDE])
                                      : bus.buf_data[i*DW +: DW];
        end else begin : g_buf_src
            assign next_p0[i] = bus.buf_data[i*DW +: DW];
        end

        if (i >= STRIDE) begin : g_fifo
            logic [DW-1:0] mem [FDEPTH];
            logic [AW-1:0] wr_ptr;
            logic [AW-1:0] rd_ptr;
            logic [AW:0]   cnt;
            logic          do_push;
            logic          do_pop;

            assign empty_f[i] = (cnt == '0);
            assign full_f[i]  = (cnt == (AW+1)'(FDEPTH));
            assign head[i]    = mem[rd_ptr];
            assign do_pop     = reuse && !empty_f[i];
            // A same-cycle pop frees a slot, so a push into a full FIFO is
            // only dropped when no pop accompanies it.
            assign do_push    = upd && (!full_f[i] || reuse);
`ifdef DW_REG_ARRAY_ERR_EN
            assign ovf_ev[i]  = upd && full_f[i] && !reuse;
            assign udf_ev[i]  = reuse && empty_f[i];
`endif

            always_ff @(posedge clk) begin
                if (!rst_n || bus.flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + 1'b1;
                    if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                    cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
                end
            end

            always_ff @(posedge clk) begin
                if (do_push) mem[wr_ptr] <= next_p0[i];
            end
        end else begin : g_no_fifo
            assign empty_f[i] = 1'b0;
            assign full_f[i]  = 1'b0;
            assign head[i]    = '0;
`ifdef DW_REG_ARRAY_ERR_EN
            assign ovf_ev[i]  = 1'b0;
            assign udf_ev[i]  = 1'b0;
`endif
        end
    end

    // Stage p0: window registers and update strobe
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            lane_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            if (upd) lane_p0 <= next_p0;
            vld_p0 <= upd;
        end
    end

`ifdef DW_REG_ARRAY_ERR_EN
    logic err_ovf_r;
    logic err_udf_r;

    // Sticky until reset; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_r <= 1'b0;
            err_udf_r <= 1'b0;
        end else begin
            if (|ovf_ev) err_ovf_r <= 1'b1;
            if (|udf_ev) err_udf_r <= 1'b1;
        end
    end

    assign bus.err_ovf = err_ovf_r;
    assign bus.err_udf = err_udf_r;
`else
    assign bus.err_ovf = 1'b0;
    assign bus.err_udf = 1'b0;
`endif

    assign bus.win_data   = lane_p0;
    assign bus.win_vld    = vld_p0;
    assign bus.fifo_empty = |empty_f;
    assign bus.fifo_full  = |full_f;

endmodule

// File: tb/tb_dw_reg_array.sv
// ---------------------------------------------------------------------------
// tb_dw_reg_array
// Directed bench for dw_reg_array at default parameters (DW=8, NREG=3,
// STRIDE=1, FDEPTH=8). Error-flag expectations follow DW_REG_ARRAY_ERR_EN.
// ---------------------------------------------------------------------------
module tb_dw_reg_array;
    localparam int DW     = 8;
    localparam int NREG   = 3;
    localparam int STRIDE = 1;
    localparam int FDEPTH = 8;

`ifdef DW_REG_ARRAY_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dw_reg_array_if #(.DW(DW), .NREG(NREG)) bus ();

    dw_reg_array #(
        .DW(DW), .NREG(NREG), .STRIDE(STRIDE), .FDEPTH(FDEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] cmd, input logic rd,
                         input logic fl, input logic [23:0] data);
        bus.arr_en        = en;
        bus.reg_array_cmd = cmd;
        bus.fifo_read     = rd;
        bus.flush         = fl;
        bus.buf_data      = data;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 2'b11, 1'b0, 1'b0, 24'h0);
        step();
        step();

        check("rst_win",   32'(bus.win_data),   32'h0);
        check("rst_vld",   32'(bus.win_vld),    32'h0);
        check("rst_empty", 32'(bus.fifo_empty), 32'h1);
        check("rst_full",  32'(bus.fifo_full),  32'h0);
        check("rst_ovf",   32'(bus.err_ovf),    32'h0);
        check("rst_udf",   32'(bus.err_udf),    32'h0);

        // LOAD 030201
        rst_n = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 1'b0, 24'h030201);
        step();
        check("load_win",   32'(bus.win_data),   32'h030201);
        check("load_vld",   32'(bus.win_vld),    32'h1);
        check("load_empty", 32'(bus.fifo_empty), 32'h0);

        // arr_en low: nothing moves
        drive(1'b0, 2'b01, 1'b0, 1'b0, 24'hFFFFFF);
        step();
        check("idle_win", 32'(bus.win_data), 32'h030201);
        check("idle_vld", 32'(bus.win_vld),  32'h0);

        // SHIFT 060504; FIFO1={02,05}, FIFO2={03,06}
        drive(1'b1, 2'b01, 1'b0, 1'b0, 24'h060504);
        step();
        check("shift_win", 32'(bus.win_data), 32'h060504);
        check("shift_vld", 32'(bus.win_vld),  32'h1);

        // REUSE: lane0<-02, lane1<-03, lane2<-07
        drive(1'b1, 2'b10, 1'b1, 1'b0, 24'h07AAAA);
        step();
        check("reuse1_win", 32'(bus.win_data), 32'h070302);
        check("reuse1_vld", 32'(bus.win_vld),  32'h1);

        // REUSE again: FIFO1={05,03}, FIFO2={06,07}
        drive(1'b1, 2'b10, 1'b1, 1'b0, 24'h08BBBB);
        step();
        check("reuse2_win", 32'(bus.win_data), 32'h080605);

        // REUSE without fifo_read acts as HOLD
        drive(1'b1, 2'b10, 1'b0, 1'b0, 24'h123456);
        step();
        check("reuse_nord_win", 32'(bus.win_data), 32'h080605);
        check("reuse_nord_vld", 32'(bus.win_vld),  32'h0);

        // Explicit HOLD
        drive(1'b1, 2'b11, 1'b1, 1'b0, 24'h654321);
        step();
        check("hold_win", 32'(bus.win_data), 32'h080605);
        check("hold_vld", 32'(bus.win_vld),  32'h0);
        check("hold_udf", 32'(bus.err_udf),  32'h0);
        check("hold_ovf", 32'(bus.err_ovf),  32'h0);

        // Flush
        drive(1'b0, 2'b11, 1'b0, 1'b1, 24'h0);
        step();
        check("flush_win",   32'(bus.win_data),   32'h0);
        check("flush_empty", 32'(bus.fifo_empty), 32'h1);
        check("flush_full",  32'(bus.fifo_full),  32'h0);

        // Fill to overflow: SHIFT k loads {20+k,10+k,k}
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b0, {8'(8'h20 + k), 8'(8'h10 + k), 8'(k)});
            step();
            if (k == 7) check("fill7_full", 32'(bus.fifo_full), 32'h0);
            if (k == 8) begin
                check("fill8_full", 32'(bus.fifo_full), 32'h1);
                check("fill8_ovf",  32'(bus.err_ovf),   32'h0);
            end
        end
        check("fill9_win",  32'(bus.win_data),  32'h291909);
        check("fill9_full", 32'(bus.fifo_full), 32'h1);
        check("fill9_ovf",  32'(bus.err_ovf),   32'(ERR_EN));

        // Heads must be the first pushes (9th dropped)
        drive(1'b1, 2'b10, 1'b1, 1'b0, 24'hAA0000);
        step();
        check("ovf_pop1_win", 32'(bus.win_data), 32'hAA2111);
        drive(1'b1, 2'b10, 1'b1, 1'b0, 24'hBB0000);
        step();
        check("ovf_pop2_win",  32'(bus.win_data),  32'hBB2212);
        check("ovf_pop2_full", 32'(bus.fifo_full), 32'h1);

        // Flush then REUSE from empty FIFOs
        drive(1'b0, 2'b11, 1'b0, 1'b1, 24'h0);
        step();
        check("flush2_empty", 32'(bus.fifo_empty), 32'h1);
        drive(1'b1, 2'b10, 1'b1, 1'b0, 24'h554433);
        step();
        check("udf_win",   32'(bus.win_data),   32'h550000);
        check("udf_vld",   32'(bus.win_vld),    32'h1);
        check("udf_flag",  32'(bus.err_udf),    32'(ERR_EN));
        check("udf_empty", 32'(bus.fifo_empty), 32'h0);

        // Flush together with LOAD: flush wins, errors retained
        drive(1'b1, 2'b00, 1'b0, 1'b1, 24'h123456);
        step();
        check("flload_win",   32'(bus.win_data),   32'h0);
        check("flload_vld",   32'(bus.win_vld),    32'h0);
        check("flload_empty", 32'(bus.fifo_empty), 32'h1);
        check("flload_ovf",   32'(bus.err_ovf),    32'(ERR_EN));
        check("flload_udf",   32'(bus.err_udf),    32'(ERR_EN));

        // Reset mid-operation
        drive(1'b1, 2'b00, 1'b0, 1'b0, 24'h010203);
        step();
        check("pre_rst_win", 32'(bus.win_data), 32'h010203);
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 1'b0, 24'h0A0B0C);
        step();
        check("mid_rst_win",   32'(bus.win_data),   32'h0);
        check("mid_rst_vld",   32'(bus.win_vld),    32'h0);
        check("mid_rst_empty", 32'(bus.fifo_empty), 32'h1);
        check("mid_rst_ovf",   32'(bus.err_ovf),    32'h0);
        check("mid_rst_udf",   32'(bus.err_udf),    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
